// File: rtl/pmod_mic3_capture_scheduler.sv
// Scans up to N_CH PMOD MIC3 ADCs on one shared SPI bus every SAMPLE_PERIOD clocks; optional status counters under PMOD_MIC3_SCHED_STATUS_EN.
// Sample appears one clock after its 16th bit is sampled; a sample arriving while the output is stalled is dropped (overrun).
module pmod_mic3_capture_scheduler #(
    parameter int N_CH          = 2,
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 2048,
    localparam int CH_W         = $clog2(N_CH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_CH-1:0]   ch_enable,
    output logic [N_CH-1:0]   cs,
    output logic              sck,
    input  logic              sdo,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [11:0]       out_data,
    output logic [CH_W-1:0]   out_ch,
`ifdef PMOD_MIC3_SCHED_STATUS_EN
    output logic              busy,
    output logic [7:0]        overrun_cnt,
    output logic [7:0]        missed_tick_cnt
`else
    output logic              busy
`endif
);

    localparam int CNT_W = $clog2(2 * CLK_DIV);
    localparam int TMR_W = $clog2(SAMPLE_PERIOD);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_QUIET = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [N_CH-1:0]  mask_q, mask_d;
    logic [11:0]      shift_q, shift_d;
    logic             done_q, done_d;
    logic [N_CH-1:0]  cs_q, cs_d;
    logic             sck_q, sck_d;
    logic             out_valid_q, out_valid_d;
    logic [11:0]      out_data_q, out_data_d;
    logic [CH_W-1:0]  out_ch_q, out_ch_d;
    logic             tick;

    function automatic logic [CH_W-1:0] lowest_set(input logic [N_CH-1:0] m);
        lowest_set = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (m[i]) lowest_set = CH_W'(i);
        end
    endfunction

    assign tick    = (timer_q == TMR_W'(SAMPLE_PERIOD - 1));
    assign timer_d = tick ? '0 : timer_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        ch_d    = ch_q;
        mask_d  = mask_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tick && (ch_enable != '0)) begin
                    mask_d  = ch_enable;
                    ch_d    = lowest_set(ch_enable);
                    cnt_d   = '0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = S_SHIFT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SHIFT: begin
                cnt_d = cnt_q + 1'b1;
                // Last low clock of a period: sck rises on this edge, so take the bit now.
                // Only the low 12 bits survive; the ADC's leading zeros shift out the top.
                if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                    shift_d = {shift_q[10:0], sdo};
                    done_d  = (bit_q == 4'd15);
                end
                if (cnt_q == CNT_W'(2 * CLK_DIV - 1)) begin
                    cnt_d = '0;
                    bit_d = bit_q + 1'b1;
                    if (bit_q == 4'd15) begin
                        mask_d[ch_q] = 1'b0;
                        state_d      = S_QUIET;
                    end
                end
            end
            S_QUIET: begin
                if (cnt_q == CNT_W'(2 * CLK_DIV - 1)) begin
                    cnt_d = '0;
                    if (mask_q != '0) begin
                        ch_d    = lowest_set(mask_q);
                        state_d = S_SETUP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pins are registered from next-state values so they switch glitch-free and track state_q.
    always_comb begin
        sck_d = !((state_d == S_SHIFT) && (cnt_d < CNT_W'(CLK_DIV)));
        cs_d  = '1;
        if ((state_d == S_SETUP) || (state_d == S_SHIFT)) cs_d[ch_d] = 1'b0;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if (done_q && (!out_valid_q || out_ready)) begin
            out_valid_d = 1'b1;
            out_data_d  = shift_q;
            out_ch_d    = ch_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            cnt_q       <= '0;
            bit_q       <= '0;
            ch_q        <= '0;
            mask_q      <= '0;
            shift_q     <= '0;
            done_q      <= 1'b0;
            cs_q        <= '1;
            sck_q       <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            ch_q        <= ch_d;
            mask_q      <= mask_d;
            shift_q     <= shift_d;
            done_q      <= done_d;
            cs_q        <= cs_d;
            sck_q       <= sck_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign cs        = cs_q;
    assign sck       = sck_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign busy      = (state_q != S_IDLE);

`ifdef PMOD_MIC3_SCHED_STATUS_EN
    logic       overrun, missed_tick;
    logic [7:0] overrun_cnt_q, overrun_cnt_d;
    logic [7:0] missed_tick_cnt_q, missed_tick_cnt_d;

    assign overrun     = done_q && out_valid_q && !out_ready;
    assign missed_tick = tick && (state_q != S_IDLE);

    always_comb begin
        overrun_cnt_d     = overrun_cnt_q;
        missed_tick_cnt_d = missed_tick_cnt_q;
        if (overrun && (overrun_cnt_q != 8'hFF)) overrun_cnt_d = overrun_cnt_q + 1'b1;
        if (missed_tick && (missed_tick_cnt_q != 8'hFF)) missed_tick_cnt_d = missed_tick_cnt_q + 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overrun_cnt_q     <= '0;
            missed_tick_cnt_q <= '0;
        end else begin
            overrun_cnt_q     <= overrun_cnt_d;
            missed_tick_cnt_q <= missed_tick_cnt_d;
        end
    end

    assign overrun_cnt     = overrun_cnt_q;
    assign missed_tick_cnt = missed_tick_cnt_q;
`endif

endmodule

// File: tb/tb_pmod_mic3_capture_scheduler.sv
// Directed bench: behavioural MIC3 models on the shared bus, a handshake monitor and hand-computed expectations.
module tb_pmod_mic3_capture_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  ch_enable;
    logic [1:0]  cs;
    logic        sck;
    logic        sdo = 1'b0;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_data;
    logic [0:0]  out_ch;
    logic        busy;

    logic [1:0]  en_s;
    logic [1:0]  cs_s;
    logic        sck_s;
    logic        sdo_s;
    logic        out_valid_s;
    logic        ready_s;
    logic [11:0] out_data_s;
    logic [0:0]  out_ch_s;
    logic        busy_s;
`ifdef PMOD_MIC3_SCHED_STATUS_EN
    logic [7:0]  ovr_cnt, mis_cnt, ovr_cnt_s, mis_cnt_s;
`endif

    always #5 clock = ~clock;

    pmod_mic3_capture_scheduler #(.N_CH(2), .CLK_DIV(4), .SAMPLE_PERIOD(400)) u_dut (
        .clock(clock), .reset(reset), .ch_enable(ch_enable), .cs(cs), .sck(sck), .sdo(sdo),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
        .busy(busy)
`ifdef PMOD_MIC3_SCHED_STATUS_EN
        , .overrun_cnt(ovr_cnt), .missed_tick_cnt(mis_cnt)
`endif
    );

    // Tick period shorter than one scan, so every other tick lands while busy.
    pmod_mic3_capture_scheduler #(.N_CH(2), .CLK_DIV(4), .SAMPLE_PERIOD(100)) u_dut_short (
        .clock(clock), .reset(reset), .ch_enable(en_s), .cs(cs_s), .sck(sck_s), .sdo(sdo_s),
        .out_valid(out_valid_s), .out_ready(ready_s), .out_data(out_data_s), .out_ch(out_ch_s),
        .busy(busy_s)
`ifdef PMOD_MIC3_SCHED_STATUS_EN
        , .overrun_cnt(ovr_cnt_s), .missed_tick_cnt(mis_cnt_s)
`endif
    );

    logic [15:0] frame [2];
    logic [12:0] acc_q [$];
    int n_chk = 0, n_pass = 0;
    int nrise = 0, sel = 0, hi_run = 0, gap_last = 0;
    int rise0 = 0, rise_s = 0, cs1_low = 0, both_low = 0, fall_low = 0, vcyc = 0, stab_viol = 0;
    logic [1:0]  prev_cs = 2'b11;
    logic        prev_sck = 1'b1, prev_sck_s = 1'b1, prev_hold = 1'b0;
    logic [12:0] prev_out = '0;

    // Mic model and bus monitor, sampled mid-cycle after the bench has driven inputs.
    always begin
        logic [15:0] fw;
        @(negedge clock);
        #1;
        if (cs != 2'b11 && prev_cs == 2'b11) begin
            sel      = (cs == 2'b01) ? 1 : 0;
            nrise    = 0;
            fw       = frame[sel];
            sdo      = fw[15];
            gap_last = hi_run;
            if (!sck) fall_low++;
        end
        if (cs == 2'b11) hi_run++;
        else hi_run = 0;
        if (cs == 2'b00) both_low++;
        if (!cs[1]) cs1_low++;
        if (sck && !prev_sck && cs != 2'b11) begin
            nrise++;
            if (cs == 2'b10) rise0++;
        end
        if (!sck && prev_sck && cs != 2'b11 && nrise < 16) begin
            fw  = frame[sel];
            sdo = fw[15 - nrise];
        end
        if (out_valid) vcyc++;
        if (out_valid && out_ready) acc_q.push_back({out_ch, out_data});
        if (out_valid && prev_hold && ({out_ch, out_data} != prev_out)) stab_viol++;
        prev_hold = out_valid && !out_ready;
        prev_out  = {out_ch, out_data};
        if (sck_s && !prev_sck_s && !cs_s[0]) rise_s++;
        prev_cs    = cs;
        prev_sck   = sck;
        prev_sck_s = sck_s;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic wait_busy(input logic lvl, input string tag);
        int n = 0;
        while (busy !== lvl && n < 2000) begin
            @(negedge clock);
            n++;
        end
        check(tag, 32'(busy), 32'(lvl));
    endtask

    task automatic expect_pop(input string tag, input logic [12:0] exp);
        logic [31:0] v;
        v = 32'hDEAD_BEEF;
        if (acc_q.size() > 0) v = 32'(acc_q.pop_front());
        check(tag, v, 32'(exp));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, r, v0, c0, b0, s0;
        logic [11:0] sdata;
        reset = 1'b1; ch_enable = 2'b00; out_ready = 1'b1;
        frame[0] = 16'h0; frame[1] = 16'h0;
        en_s = 2'b01; sdo_s = 1'b1; ready_s = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_cs", 32'(cs), 32'h3);
        check("rst_sck", 32'(sck), 1);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data", 32'(out_data), 0);
        check("rst_ch", 32'(out_ch), 0);
        check("rst_busy", 32'(busy), 0);
        reset = 1'b0;

        // Short-period instance: scan = 4+128+8 clocks, next accepted tick two periods later
        n = 0;
        while (!busy_s && n < 1000) begin @(negedge clock); n++; end
        check("t4_start", 32'(busy_s), 1);
        r = rise_s; n = 0; sdata = '0;
        while (busy_s && n < 1000) begin
            @(negedge clock); n++;
            if (out_valid_s) sdata = out_data_s;
        end
        check("t4_len", n, 140);
        check("t4_data", 32'(sdata), 32'hFFF);
        check("t4_bits", rise_s - r, 16);
        while (!busy_s && n < 1000) begin @(negedge clock); n++; end
        check("t4_gap", n, 200);
`ifdef PMOD_MIC3_SCHED_STATUS_EN
        check("t4_missed", 32'(mis_cnt_s), 1);
`endif

        // Single channel 0
        ch_enable = 2'b01; frame[0] = 16'h0ABC;
        v0 = vcyc; r = rise0; c0 = cs1_low;
        wait_busy(1'b1, "t1_start");
        wait_busy(1'b0, "t1_end");
        repeat (2) @(negedge clock);
        check("t1_count", acc_q.size(), 1);
        expect_pop("t1_smp", {1'b0, 12'hABC});
        check("t1_vpulse", vcyc - v0, 1);
        check("t1_rises", rise0 - r, 16);
        check("t1_cs1", cs1_low - c0, 0);

        // Both channels, ascending order
        ch_enable = 2'b11; frame[0] = 16'h0123; frame[1] = 16'h0FED;
        b0 = both_low;
        wait_busy(1'b1, "t2_start");
        wait_busy(1'b0, "t2_end");
        repeat (2) @(negedge clock);
        check("t2_count", acc_q.size(), 2);
        expect_pop("t2_smp0", {1'b0, 12'h123});
        expect_pop("t2_smp1", {1'b1, 12'hFED});
        check("t2_both_low", both_low - b0, 0);
        check("t2_quiet", gap_last, 8);
        check("t2_cs_sck_low", fall_low, 0);

        // Stalled consumer across two scans
        out_ready = 1'b0; ch_enable = 2'b01; frame[0] = 16'h0555;
        s0 = stab_viol;
        wait_busy(1'b1, "t3_start1");
        wait_busy(1'b0, "t3_end1");
        frame[0] = 16'h0AAA;
        wait_busy(1'b1, "t3_start2");
        wait_busy(1'b0, "t3_end2");
        @(negedge clock);
        check("t3_valid", 32'(out_valid), 1);
        check("t3_held", {19'b0, out_ch, out_data}, 32'h555);
        check("t3_stable", stab_viol - s0, 0);
`ifdef PMOD_MIC3_SCHED_STATUS_EN
        check("t3_overrun", 32'(ovr_cnt), 1);
`endif
        out_ready = 1'b1;
        @(negedge clock);
        expect_pop("t3_drain", {1'b0, 12'h555});
        check("t3_valid_clr", 32'(out_valid), 0);
        check("t3_empty", acc_q.size(), 0);

        // Enable change mid-scan applies to the next scan only
        ch_enable = 2'b01; frame[0] = 16'h0111; frame[1] = 16'h0222;
        wait_busy(1'b1, "t6_start1");
        ch_enable = 2'b10;
        wait_busy(1'b0, "t6_end1");
        repeat (2) @(negedge clock);
        check("t6_count1", acc_q.size(), 1);
        expect_pop("t6_smp1", {1'b0, 12'h111});
        wait_busy(1'b1, "t6_start2");
        wait_busy(1'b0, "t6_end2");
        repeat (2) @(negedge clock);
        expect_pop("t6_smp2", {1'b1, 12'h222});

        // Reset in the middle of a frame
        ch_enable = 2'b01; frame[0] = 16'h0777;
        wait_busy(1'b1, "t5_start");
        r = rise0; n = 0;
        while (rise0 - r < 7 && n < 500) begin @(negedge clock); n++; end
        check("t5_bit", rise0 - r, 7);
        #2 reset = 1'b1;
        #1;
        check("t5_cs", 32'(cs), 32'h3);
        check("t5_sck", 32'(sck), 1);
        check("t5_valid", 32'(out_valid), 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        frame[0] = 16'h0321;
        r = rise0;
        wait_busy(1'b1, "t5_start2");
        wait_busy(1'b0, "t5_end2");
        repeat (2) @(negedge clock);
        check("t5_count", acc_q.size(), 1);
        expect_pop("t5_smp", {1'b0, 12'h321});
        check("t5_rises", rise0 - r, 16);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
